// File: rtl/prog_mem_pkg.sv
// Shared state encoding and default widths for the program-memory responder.
package prog_mem_pkg;

  localparam int DEFAULT_ADDR_BITS = 8;
  localparam int DEFAULT_DATA_BITS = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCEPT  = 2'd1,
    READ    = 2'd2,
    RESPOND = 2'd3
  } state_t;

endpackage

// File: rtl/pmem_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past last_grant and wraps.
module pmem_rr_arbiter
  import prog_mem_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] request,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [NUM_PORTS-1:0] grant_onehot,
  output logic [IDX_W-1:0]     grant_index,
  output logic                 grant_valid
);

  int cand;

  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned infers a latch.
  always_comb begin
    grant_onehot = '0;
    grant_index  = '0;
    grant_valid  = 1'b0;
    cand         = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!grant_valid && request[IDX_W'(cand)]) begin
        grant_valid                 = 1'b1;
        grant_index                 = IDX_W'(cand);
        grant_onehot[IDX_W'(cand)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prog_mem_responder.sv
// Instruction-cache fill responder: round-robin grant, fixed-latency memory read, two-pulse ready.
// Define PROG_MEM_RESP_BOUNDS_CHECK_EN to answer addresses >= PROGRAM_MEM_DEPTH with zero, no memory access.
module prog_mem_responder
  import prog_mem_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int PROGRAM_MEM_DATA_BITS = DEFAULT_DATA_BITS,
  parameter int NUM_CONSUMERS         = 4,
  parameter int MEM_LATENCY           = 2,
  parameter int PROGRAM_MEM_DEPTH     = 256
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic [NUM_CONSUMERS-1:0]                         consumer_read_valid,
  input  logic [NUM_CONSUMERS*PROGRAM_MEM_ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                         consumer_read_ready,
  output logic [NUM_CONSUMERS*PROGRAM_MEM_DATA_BITS-1:0]   consumer_read_data,
  output logic                                             mem_read_en,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]                 mem_read_address,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0]                 mem_read_data,
  output logic                                             busy
);

  localparam int AW    = PROGRAM_MEM_ADDR_BITS;
  localparam int DW    = PROGRAM_MEM_DATA_BITS;
  localparam int N     = NUM_CONSUMERS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY);

`ifdef PROG_MEM_RESP_BOUNDS_CHECK_EN
  localparam bit BOUNDS_CHECK = 1'b1;
`else
  localparam bit BOUNDS_CHECK = 1'b0;
`endif

  state_t           state, state_next;
  logic [IDX_W-1:0] grant_q, last_grant_q, arb_index;
  logic [N-1:0]     arb_onehot;
  logic             arb_valid;
  logic [AW-1:0]    addr_lane [N];
  logic [AW-1:0]    req_addr;
  logic             req_oob;
  logic             oob_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    lane_q [N];
  logic [N-1:0]     ready_next;
  logic             en_next;
  logic             capture;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign addr_lane[i]                = consumer_read_address[i*AW +: AW];
    assign consumer_read_data[i*DW +: DW] = lane_q[i];
  end

  assign req_addr = addr_lane[arb_index];
  assign req_oob  = BOUNDS_CHECK && (32'(req_addr) >= 32'(PROGRAM_MEM_DEPTH));

  pmem_rr_arbiter #(.NUM_PORTS(N), .IDX_W(IDX_W)) u_arbiter (
    .request      (consumer_read_valid),
    .last_grant   (last_grant_q),
    .grant_onehot (arb_onehot),
    .grant_index  (arb_index),
    .grant_valid  (arb_valid)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Outputs are computed for the state being entered and registered below.
  always_comb begin
    state_next = state;
    ready_next = '0;
    en_next    = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          state_next = ACCEPT;
          ready_next = arb_onehot;
          en_next    = !req_oob;
        end
      end
      ACCEPT: begin
        if (oob_q) begin
          state_next          = RESPOND;
          ready_next[grant_q] = 1'b1;
          capture             = 1'b1;
        end else begin
          state_next = READ;
        end
      end
      READ: begin
        if (cnt_q == CNT_W'(1)) begin
          state_next          = RESPOND;
          ready_next[grant_q] = 1'b1;
          capture             = 1'b1;
        end
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the data lanes are architectural outputs that must read zero after
  // reset, so this small register array is reset explicitly.
  always_ff @(posedge clk) begin
    if (reset) begin
      consumer_read_ready <= '0;
      mem_read_en         <= 1'b0;
      mem_read_address    <= '0;
      busy                <= 1'b0;
      grant_q             <= '0;
      last_grant_q        <= IDX_W'(N - 1);
      oob_q               <= 1'b0;
      cnt_q               <= '0;
      for (int i = 0; i < N; i++) lane_q[i] <= '0;
    end else begin
      consumer_read_ready <= ready_next;
      mem_read_en         <= en_next;
      busy                <= (state_next != IDLE);
      if (state == IDLE && arb_valid) begin
        grant_q          <= arb_index;
        oob_q            <= req_oob;
        mem_read_address <= req_addr;
      end
      if (state == ACCEPT)    cnt_q <= CNT_LOAD;
      else if (state == READ) cnt_q <= cnt_q - 1'b1;
      // Out-of-range requests answer zero; the memory bus is never looked at.
      if (capture)            lane_q[grant_q] <= oob_q ? '0 : mem_read_data;
      if (state == RESPOND)   last_grant_q <= grant_q;
    end
  end

endmodule

// File: tb/tb_prog_mem_responder.sv
// Scoreboard bench for prog_mem_responder: expected pulses are queued by the stimulus, a negedge monitor compares.
module tb_prog_mem_responder;

  localparam int N     = 4;
  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int LAT   = 2;
  localparam int DEPTH = 128;

`ifdef PROG_MEM_RESP_BOUNDS_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  typedef struct { int cyc; int port; bit is_data; logic [DW-1:0] data; } ev_t;
  typedef struct { int cyc; logic [AW-1:0] addr; } mr_t;
  typedef struct { int cyc; logic [N-1:0] rdy; logic [N*DW-1:0] lanes; } log_t;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]    valid;
  logic [N*AW-1:0] addr;
  logic [N-1:0]    ready;
  logic [N*DW-1:0] rd_data;
  logic            mem_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data;
  logic            busy;

  logic [N-1:0]    aux_valid;
  logic [N*AW-1:0] aux_addr;
  logic [N-1:0]    l1_ready, l4_ready;
  logic [N*DW-1:0] l1_data, l4_data;
  logic            l1_en, l4_en, l1_busy, l4_busy;
  logic [AW-1:0]   l1_addr, l4_addr;
  logic [DW-1:0]   l1_mdata, l4_mdata;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  ev_t ev_q[$];
  mr_t mr_q[$];
  log_t l1_log[$], l4_log[$];
  ev_t mon_ev;
  mr_t mon_mr;
  logic [DW-1:0] exp_lane [N];
  bit phase [N];
  int remaining [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    if (a == 8'h05) return 16'hA1B2;
    return {a ^ 8'h5A, ~a};
  endfunction

  // Program memory models: one shift pipe per DUT, tapped at that DUT's latency.
  logic          pv [3][4];
  logic [AW-1:0] pa [3][4];
  always @(posedge clk) begin
    pv[0][0] <= mem_en; pa[0][0] <= mem_addr;
    pv[1][0] <= l1_en;  pa[1][0] <= l1_addr;
    pv[2][0] <= l4_en;  pa[2][0] <= l4_addr;
    for (int k = 0; k < 3; k++)
      for (int s = 1; s < 4; s++) begin
        pv[k][s] <= pv[k][s-1];
        pa[k][s] <= pa[k][s-1];
      end
  end
  assign mem_data = pv[0][LAT-1] ? word(pa[0][LAT-1]) : 16'hDEAD;
  assign l1_mdata = pv[1][0]     ? word(pa[1][0])     : 16'hDEAD;
  assign l4_mdata = pv[2][3]     ? word(pa[2][3])     : 16'hDEAD;

  prog_mem_responder #(
    .PROGRAM_MEM_ADDR_BITS(AW), .PROGRAM_MEM_DATA_BITS(DW), .NUM_CONSUMERS(N),
    .MEM_LATENCY(LAT), .PROGRAM_MEM_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(valid), .consumer_read_address(addr),
    .consumer_read_ready(ready), .consumer_read_data(rd_data),
    .mem_read_en(mem_en), .mem_read_address(mem_addr), .mem_read_data(mem_data),
    .busy(busy)
  );

  prog_mem_responder #(
    .PROGRAM_MEM_ADDR_BITS(AW), .PROGRAM_MEM_DATA_BITS(DW), .NUM_CONSUMERS(N),
    .MEM_LATENCY(1), .PROGRAM_MEM_DEPTH(DEPTH)
  ) dut_l1 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(aux_valid), .consumer_read_address(aux_addr),
    .consumer_read_ready(l1_ready), .consumer_read_data(l1_data),
    .mem_read_en(l1_en), .mem_read_address(l1_addr), .mem_read_data(l1_mdata),
    .busy(l1_busy)
  );

  prog_mem_responder #(
    .PROGRAM_MEM_ADDR_BITS(AW), .PROGRAM_MEM_DATA_BITS(DW), .NUM_CONSUMERS(N),
    .MEM_LATENCY(4), .PROGRAM_MEM_DEPTH(DEPTH)
  ) dut_l4 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(aux_valid), .consumer_read_address(aux_addr),
    .consumer_read_ready(l4_ready), .consumer_read_data(l4_data),
    .mem_read_en(l4_en), .mem_read_address(l4_addr), .mem_read_data(l4_mdata),
    .busy(l4_busy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse and memory strobe must match the head of its queue.
  always @(negedge clk) begin
    if (reset) begin
      for (int p = 0; p < N; p++) exp_lane[p] = '0;
    end else begin
      if (ready != '0) begin
        if (ev_q.size() == 0) begin
          check("unexpected_ready", 64'(ready), 64'd0);
        end else begin
          mon_ev = ev_q.pop_front();
          check("ready_cycle", 64'(cyc), 64'(mon_ev.cyc));
          check("ready_port", 64'(ready), 64'(4'(1) << mon_ev.port));
          check("busy_on_pulse", 64'(busy), 64'd1);
          if (mon_ev.is_data) begin
            for (int p = 0; p < N; p++)
              check($sformatf("lane%0d", p), 64'(rd_data[p*DW +: DW]),
                    64'((p == mon_ev.port) ? mon_ev.data : exp_lane[p]));
            exp_lane[mon_ev.port] = mon_ev.data;
          end
        end
      end
      if (mem_en) begin
        if (mr_q.size() == 0) begin
          check("unexpected_mem_read", 64'(mem_addr), 64'hFFFF);
        end else begin
          mon_mr = mr_q.pop_front();
          check("mem_read_cycle", 64'(cyc), 64'(mon_mr.cyc));
          check("mem_read_addr", 64'(mem_addr), 64'(mon_mr.addr));
        end
      end
      if (l1_ready != '0) l1_log.push_back('{cyc, l1_ready, l1_data});
      if (l4_ready != '0) l4_log.push_back('{cyc, l4_ready, l4_data});
    end
  end

  // Requester behaviour: each port drops valid after its n-th accept pulse.
  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      for (int p = 0; p < N; p++)
        if (ready[p]) begin
          if (!phase[p]) begin
            remaining[p]--;
            if (remaining[p] <= 0) valid[p] = 1'b0;
          end
          phase[p] = !phase[p];
        end
    end
  endtask

  task automatic clear_requesters();
    valid = '0;
    for (int p = 0; p < N; p++) begin
      phase[p]     = 1'b0;
      remaining[p] = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run_cycles(2);
    reset = 1'b0;
    clear_requesters();
  endtask

  task automatic request(input int p, input logic [AW-1:0] a, input int n);
    valid[p]          = 1'b1;
    addr[p*AW +: AW]  = a;
    remaining[p]      = n;
  endtask

  // Queues one service starting with its accept pulse at cycle acc; returns the next accept cycle.
  task automatic expect_service(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input int acc, input bit oob, output int next_acc);
    ev_q.push_back('{acc, p, 1'b0, 16'h0});
    if (oob) begin
      ev_q.push_back('{acc + 1, p, 1'b1, 16'h0});
      next_acc = acc + 3;
    end else begin
      mr_q.push_back('{acc, a});
      ev_q.push_back('{acc + LAT + 1, p, 1'b1, d});
      next_acc = acc + LAT + 3;
    end
  endtask

  initial begin
    int c, nxt;
    reset = 1'b1; valid = '0; addr = '0; aux_valid = '0; aux_addr = '0;
    do_reset();
    run_cycles(1);
    check("rst_ready",    64'(ready),    64'd0);
    check("rst_mem_en",   64'(mem_en),   64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_lanes",    rd_data,       64'd0);

    // Single read, port 0, address 0x05.
    c = cyc;
    request(0, 8'h05, 1);
    expect_service(0, 8'h05, 16'hA1B2, c + 1, 1'b0, nxt);
    run_cycles(2);
    check("busy_in_read", 64'(busy), 64'd1);
    run_cycles(nxt - cyc);
    check("busy_idle", 64'(busy), 64'd0);

    // Simultaneous 0,1,2 from reset, then 0 and 3 together.
    do_reset();
    c = cyc;
    request(0, 8'h00, 1); request(1, 8'h10, 1); request(2, 8'h22, 1);
    expect_service(0, 8'h00, 16'h5AFF, c + 1, 1'b0, nxt);
    expect_service(1, 8'h10, 16'h4AEF, nxt, 1'b0, nxt);
    expect_service(2, 8'h22, 16'h78DD, nxt, 1'b0, nxt);
    run_cycles(nxt - cyc);
    c = cyc;
    request(0, 8'h41, 1); request(3, 8'hFF, 1);
    expect_service(3, 8'hFF, 16'hA500, c + 1, 1'b0, nxt);
    expect_service(0, 8'h41, 16'h1BBE, nxt, 1'b0, nxt);
    run_cycles(nxt - cyc);

    // Ports 1 and 2 held valid for two services each: strict alternation.
    c = cyc;
    request(1, 8'h10, 2); request(2, 8'h22, 2);
    expect_service(1, 8'h10, 16'h4AEF, c + 1, 1'b0, nxt);
    expect_service(2, 8'h22, 16'h78DD, nxt, 1'b0, nxt);
    expect_service(1, 8'h10, 16'h4AEF, nxt, 1'b0, nxt);
    expect_service(2, 8'h22, 16'h78DD, nxt, 1'b0, nxt);
    run_cycles(nxt - cyc);

    // Reset while the read is in flight.
    c = cyc;
    request(1, 8'h33, 1);
    ev_q.push_back('{c + 1, 1, 1'b0, 16'h0});
    mr_q.push_back('{c + 1, 8'h33});
    run_cycles(2);
    reset = 1'b1;
    run_cycles(1);
    check("abort_ready",    64'(ready),    64'd0);
    check("abort_mem_en",   64'(mem_en),   64'd0);
    check("abort_busy",     64'(busy),     64'd0);
    check("abort_mem_addr", 64'(mem_addr), 64'd0);
    check("abort_lanes",    rd_data,       64'd0);
    reset = 1'b0;
    clear_requesters();
    run_cycles(4);
    check("lanes_after_abort", rd_data, 64'd0);
    c = cyc;
    request(3, 8'h12, 1); request(0, 8'h34, 1);
    expect_service(0, 8'h34, 16'h6ECB, c + 1, 1'b0, nxt);
    expect_service(3, 8'h12, 16'h48ED, nxt, 1'b0, nxt);
    run_cycles(nxt - cyc);

    // Depth boundary: 0x80 and 0x90 are out of range only with bounds checking, 0x7F never is.
    c = cyc;
    request(1, 8'h80, 1); request(2, 8'h90, 1); request(3, 8'h7F, 1);
    expect_service(1, 8'h80, BCHK ? 16'h0000 : 16'hDA7F, c + 1, BCHK, nxt);
    expect_service(2, 8'h90, BCHK ? 16'h0000 : 16'hCA6F, nxt, BCHK, nxt);
    expect_service(3, 8'h7F, 16'h2580, nxt, 1'b0, nxt);
    run_cycles(nxt - cyc);

    // Latency 1 and 4 instances: port 2 reads 0x05.
    c = cyc;
    aux_valid[2] = 1'b1;
    aux_addr[2*AW +: AW] = 8'h05;
    run_cycles(1);
    aux_valid = '0;
    run_cycles(8);
    check("l1_pulses", 64'(l1_log.size()), 64'd2);
    if (l1_log.size() >= 2) begin
      check("l1_accept_cycle", 64'(l1_log[0].cyc), 64'(c + 1));
      check("l1_data_cycle",   64'(l1_log[1].cyc), 64'(c + 3));
      check("l1_ready",        64'(l1_log[1].rdy), 64'h4);
      check("l1_lanes",        l1_log[1].lanes,    64'h0000_A1B2_0000_0000);
    end
    check("l4_pulses", 64'(l4_log.size()), 64'd2);
    if (l4_log.size() >= 2) begin
      check("l4_accept_cycle", 64'(l4_log[0].cyc), 64'(c + 1));
      check("l4_data_cycle",   64'(l4_log[1].cyc), 64'(c + 6));
      check("l4_ready",        64'(l4_log[1].rdy), 64'h4);
      check("l4_lanes",        l4_log[1].lanes,    64'h0000_A1B2_0000_0000);
    end
    check("l1_idle_end", 64'(l1_busy), 64'd0);
    check("l4_idle_end", 64'(l4_busy), 64'd0);

    check("events_left",    64'(ev_q.size()), 64'd0);
    check("mem_reads_left", 64'(mr_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
